// File: rtl/audio_button_poller.sv
// Avalon-MM read master that polls a 1-bit button PIO at a fixed rate,
// debounces the sampled level and reports debounced presses.
module audio_button_poller #(
  parameter int POLL_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int READ_LATENCY     = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic             level,
  output logic             press_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             overrun,
  output logic             busy
);

  localparam int            TW        = $clog2(POLL_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(POLL_DIV - 1);
  localparam logic [3:0]    DB_N      = 4'(DEBOUNCE_SAMPLES);
  localparam logic [2:0]    LAT_N     = 3'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    lat_cnt;
  logic [3:0]    db_cnt;
  logic          tick;
  logic          sample;
  logic          unused_rdata;

  assign avm_address  = 2'b00;
  assign tick         = enable && (tick_cnt == TICK_LAST);
  assign sample       = avm_readdata[0];
  assign unused_rdata = ^avm_readdata[31:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   tick_cnt <= '0;
    else if (!enable || tick) tick_cnt <= '0;
    else            tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      lat_cnt     <= '0;
      db_cnt      <= '0;
      level       <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= '0;
      overrun     <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (press_pulse) press_count <= press_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= READ;
            avm_read <= 1'b1;
            busy     <= 1'b1;
          end
        end
        READ: begin
          // ticks during a transaction are dropped, never queued
          if (tick) overrun <= 1'b1;
          if (!avm_waitrequest) begin
            state    <= WAIT;
            avm_read <= 1'b0;
            lat_cnt  <= LAT_N;
          end
        end
        WAIT: begin
          if (tick) overrun <= 1'b1;
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (sample == level) begin
              db_cnt <= '0;
            end else if (db_cnt + 4'd1 == DB_N) begin
              level       <= sample;
              db_cnt      <= '0;
              press_pulse <= sample;
            end else begin
              db_cnt <= db_cnt + 4'd1;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_button_poller.sv
// Bench for audio_button_poller: two instances (nominal and wrap/latency
// configurations) driven by a bench-side slave and checked against a sample model.
module tb_audio_button_poller;
  localparam int PD_A = 8, DS_A = 3, RL_A = 1, CW_A = 16;
  localparam int PD_B = 6, DS_B = 1, RL_B = 3, CW_B = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      enable;
  logic [1:0]      waitreq;
  logic [31:0]     rdata [2];
  logic [1:0]      avm_read, level, press_pulse, overrun, busy;
  logic [1:0]      addr_a, addr_b;
  logic [CW_A-1:0] pc_a;
  logic [CW_B-1:0] pc_b;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  audio_button_poller #(.POLL_DIV(PD_A), .DEBOUNCE_SAMPLES(DS_A), .READ_LATENCY(RL_A), .CNT_W(CW_A)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable[0]), .avm_address(addr_a), .avm_read(avm_read[0]),
    .avm_waitrequest(waitreq[0]), .avm_readdata(rdata[0]), .level(level[0]), .press_pulse(press_pulse[0]),
    .press_count(pc_a), .overrun(overrun[0]), .busy(busy[0]));

  audio_button_poller #(.POLL_DIV(PD_B), .DEBOUNCE_SAMPLES(DS_B), .READ_LATENCY(RL_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(enable[1]), .avm_address(addr_b), .avm_read(avm_read[1]),
    .avm_waitrequest(waitreq[1]), .avm_readdata(rdata[1]), .level(level[1]), .press_pulse(press_pulse[1]),
    .press_count(pc_b), .overrun(overrun[1]), .busy(busy[1]));

  int errors = 0, checks = 0;
  int taken[2], stall_left[2], cd[2], flip_cyc[2], pulses[2], wide[2], pulse_cyc[2];
  int run_m[2], presses_m[2];
  bit dflt[2], lvl_m[2], pend[2];
  bit sq0[$], sq1[$];

  function automatic bit next_sample(input int d);
    if (d == 0) return (sq0.size() > 0) ? sq0.pop_front() : dflt[0];
    return (sq1.size() > 0) ? sq1.pop_front() : dflt[1];
  endfunction

  // Reference debounce: level follows the input once DS consecutive samples disagree with it.
  function automatic void model_capture(input int d, input bit s);
    int ds;
    ds = (d == 0) ? DS_A : DS_B;
    if (s == lvl_m[d]) run_m[d] = 0;
    else begin
      run_m[d]++;
      if (run_m[d] == ds) begin
        lvl_m[d] = s;
        run_m[d] = 0;
        if (s) begin presses_m[d]++; flip_cyc[d] = cyc; end
      end
    end
  endfunction

  function automatic int exp_pc(input int d);
    return (d == 0) ? presses_m[0] % (1 << CW_A) : presses_m[1] % (1 << CW_B);
  endfunction

  function automatic int get_pc(input int d);
    return (d == 0) ? int'(pc_a) : int'(pc_b);
  endfunction

  // Slave: fixed-latency responder; non-capture wait cycles carry the inverted sample bit.
  task automatic slave(input int d);
    logic [31:0] r;
    int lat;
    lat = (d == 0) ? RL_A : RL_B;
    forever begin
      @(negedge clk);
      if (!reset_n) begin cd[d] = 0; waitreq[d] = 1'b0; continue; end
      r = $urandom;
      if (cd[d] > 0) begin
        cd[d]--;
        if (cd[d] == 0) begin
          r[0] = pend[d];
          model_capture(d, pend[d]);
          taken[d]++;
        end else r[0] = ~pend[d];
      end
      rdata[d] = r;
      if (avm_read[d] && stall_left[d] > 0) begin waitreq[d] = 1'b1; stall_left[d]--; end
      else waitreq[d] = 1'b0;
      if (avm_read[d] && !waitreq[d]) begin cd[d] = lat; pend[d] = next_sample(d); end
    end
  endtask

  task automatic monitor(input int d);
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (press_pulse[d]) begin
        pulses[d]++;
        pulse_cyc[d] = cyc;
        if (prev) wide[d]++;
      end
      prev = press_pulse[d];
    end
  endtask

  task automatic wait_taken(input int d, input int n, output bit ok);
    int tgt;
    tgt = taken[d] + n;
    ok = 1'b0;
    for (int i = 0; i < 100 * n + 100; i++) begin
      @(negedge clk);
      if (taken[d] >= tgt) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_read_rise(input int d, output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (avm_read[d]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok; int n;
    reset_n = 1'b0; enable = 2'b00; waitreq = 2'b00; rdata[0] = '0; rdata[1] = '0;
    stall_left[0] = 50;
    repeat (3) @(negedge clk);
    checks++;
    if ({avm_read, level, press_pulse, overrun, busy, addr_a, addr_b, pc_a, pc_b} !== '0)
      begin errors++; $display("FAIL reset_state: got %h want 0", {avm_read, level, press_pulse, overrun, busy, pc_a, pc_b}); end
    reset_n = 1'b1; enable[0] = 1'b1;
    wait_read_rise(0, ok, n);
    checks++;
    if (!ok || n != PD_A) begin errors++; $display("FAIL first_read_delay: got %0d want %0d", n, PD_A); end
    #2;
    checks++;
    if (busy[0] !== 1'b1 || avm_read[0] !== 1'b1)
      begin errors++; $display("FAIL stalled_read: busy=%b read=%b want 1 1", busy[0], avm_read[0]); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read[0], busy[0], overrun[0], level[0], press_pulse[0], pc_a, addr_a} !== '0)
      begin errors++; $display("FAIL async_reset: got %h want 0", {avm_read[0], busy[0], overrun[0], level[0], pc_a}); end
    lvl_m[0] = 1'b0; run_m[0] = 0; presses_m[0] = 0; stall_left[0] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_read_rise(0, ok, n);
    checks++;
    if (!ok || n != PD_A) begin errors++; $display("FAIL read_delay_after_reset: got %0d want %0d", n, PD_A); end
  endtask

  task automatic test_nominal();
    bit ok; bit prevr; int rises[$]; int wide_rd;
    wait_taken(0, 1, ok);
    dflt[0] = 1'b1;
    wait_taken(0, 2, ok);
    checks++;
    if (!ok || level[0] !== 1'b0) begin errors++; $display("FAIL nominal_two_samples: level=%b want 0", level[0]); end
    wait_taken(0, 1, ok);
    checks++;
    if (!ok || level[0] !== 1'b1) begin errors++; $display("FAIL nominal_rise: level=%b want 1", level[0]); end
    checks++;
    if (pc_a !== 16'd1 || pulses[0] != 1 || wide[0] != 0)
      begin errors++; $display("FAIL nominal_press: count=%0d pulses=%0d wide=%0d want 1 1 0", pc_a, pulses[0], wide[0]); end
    checks++;
    if (pulse_cyc[0] != flip_cyc[0] + 1)
      begin errors++; $display("FAIL nominal_pulse_time: cycle %0d want %0d", pulse_cyc[0], flip_cyc[0] + 1); end
    prevr = 1'b0; wide_rd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avm_read[0]) begin if (!prevr) rises.push_back(cyc); else wide_rd++; end
      prevr = avm_read[0];
    end
    checks++;
    if (rises.size() < 4 || wide_rd != 0)
      begin errors++; $display("FAIL read_pulses: rises=%0d long=%0d want >=4 0", rises.size(), wide_rd); end
    for (int i = 1; i < 4 && i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != PD_A)
        begin errors++; $display("FAIL read_period: got %0d want %0d", rises[i] - rises[i-1], PD_A); end
    end
  endtask

  task automatic test_release();
    bit ok;
    wait_taken(0, 1, ok);
    dflt[0] = 1'b0;
    wait_taken(0, 2, ok);
    checks++;
    if (!ok || level[0] !== 1'b1) begin errors++; $display("FAIL release_two: level=%b want 1", level[0]); end
    wait_taken(0, 1, ok);
    checks++;
    if (!ok || level[0] !== 1'b0 || pc_a !== 16'd1 || pulses[0] != 1)
      begin errors++; $display("FAIL release: level=%b count=%0d pulses=%0d want 0 1 1", level[0], pc_a, pulses[0]); end
  endtask

  task automatic test_bounce();
    bit ok; bit seq[8];
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    wait_taken(0, 1, ok);
    for (int i = 0; i < 8; i++) sq0.push_back(seq[i]);
    for (int i = 0; i < 7; i++) begin
      wait_taken(0, 1, ok);
      checks++;
      if (!ok || level[0] !== 1'b0) begin errors++; $display("FAIL bounce_hold[%0d]: level=%b want 0", i, level[0]); end
    end
    wait_taken(0, 1, ok);
    checks++;
    if (!ok || level[0] !== 1'b1 || pc_a !== 16'd2 || pulses[0] != 2)
      begin errors++; $display("FAIL bounce_rise: level=%b count=%0d pulses=%0d want 1 2 2", level[0], pc_a, pulses[0]); end
  endtask

  task automatic test_random();
    bit ok; bit b; int rep;
    wait_taken(0, 1, ok);
    for (int it = 0; it < 14; it++) begin
      b = 1'($urandom_range(0, 1));
      rep = $urandom_range(1, 4);
      for (int k = 0; k < rep; k++) sq0.push_back(b);
      wait_taken(0, rep, ok);
      checks++;
      if (!ok || level[0] !== lvl_m[0] || get_pc(0) != exp_pc(0))
        begin errors++; $display("FAIL random[%0d]: level=%b count=%0d want %b %0d", it, level[0], get_pc(0), lvl_m[0], exp_pc(0)); end
    end
    checks++;
    if (pulses[0] != presses_m[0] || wide[0] != 0)
      begin errors++; $display("FAIL random_pulses: pulses=%0d wide=%0d want %0d 0", pulses[0], wide[0], presses_m[0]); end
  endtask

  task automatic test_stall();
    bit ok; int n, high, t;
    wait_taken(0, 1, ok);
    checks++;
    if (overrun[0] !== 1'b0) begin errors++; $display("FAIL overrun_idle: got %b want 0", overrun[0]); end
    stall_left[0] = 10;
    wait_read_rise(0, ok, n);
    t = taken[0];
    high = ok ? 1 : 0;
    for (int i = 0; i < 40 && ok; i++) begin
      @(negedge clk);
      if (!avm_read[0]) break;
      high++;
    end
    checks++;
    if (high != 11) begin errors++; $display("FAIL stall_read_len: got %0d want 11", high); end
    checks++;
    if (overrun[0] !== 1'b1) begin errors++; $display("FAIL stall_overrun: got %b want 1", overrun[0]); end
    repeat (3) @(negedge clk);
    checks++;
    if (taken[0] - t != 1) begin errors++; $display("FAIL stall_samples: got %0d want 1", taken[0] - t); end
    wait_taken(0, 1, ok);
    checks++;
    if (overrun[0] !== 1'b1 || level[0] !== lvl_m[0])
      begin errors++; $display("FAIL overrun_sticky: overrun=%b level=%b want 1 %b", overrun[0], level[0], lvl_m[0]); end
  endtask

  task automatic test_enable_drop();
    bit ok; int n, rises;
    wait_taken(0, 1, ok);
    sq0.push_back(~lvl_m[0]);
    stall_left[0] = 3;
    wait_read_rise(0, ok, n);
    enable[0] = 1'b0;
    wait_taken(0, 1, ok);
    checks++;
    if (!ok || run_m[0] != 1) begin errors++; $display("FAIL enable_drop_complete: ok=%b run=%0d want 1 1", ok, run_m[0]); end
    rises = 0;
    for (int i = 0; i < 3 * PD_A; i++) begin @(negedge clk); if (avm_read[0]) rises++; end
    checks++;
    if (rises != 0 || busy[0] !== 1'b0)
      begin errors++; $display("FAIL enable_drop_idle: reads=%0d busy=%b want 0 0", rises, busy[0]); end
    checks++;
    if (level[0] !== lvl_m[0] || get_pc(0) != exp_pc(0))
      begin errors++; $display("FAIL enable_drop_state: level=%b count=%0d want %b %0d", level[0], get_pc(0), lvl_m[0], exp_pc(0)); end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 16; i++) begin sq1.push_back(1'b1); sq1.push_back(1'b0); end
    enable[1] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wait_taken(1, 2, ok);
      checks++;
      if (!ok || level[1] !== 1'b0 || get_pc(1) != exp_pc(1) || get_pc(1) != i % 16)
        begin errors++; $display("FAIL wrap[%0d]: level=%b count=%0d want 0 %0d", i, level[1], get_pc(1), i % 16); end
    end
    checks++;
    if (pulses[1] != 16 || wide[1] != 0 || pulse_cyc[1] != flip_cyc[1] + 1)
      begin errors++; $display("FAIL wrap_pulses: pulses=%0d wide=%0d at %0d want 16 0 %0d", pulses[1], wide[1], pulse_cyc[1], flip_cyc[1] + 1); end
    checks++;
    if (overrun[1] !== 1'b0) begin errors++; $display("FAIL wrap_overrun: got %b want 0", overrun[1]); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      slave(0); slave(1); monitor(0); monitor(1);
    join_none
    test_reset();
    test_nominal();
    test_release();
    test_bounce();
    test_random();
    test_stall();
    test_enable_drop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
